pc_seq_unit: RTL and testbench

- Next-generation program-counter unit for the tinyRISC core.
- Holds the PC register and selects the next PC from four sources: sequential, branch-relative, absolute jump, and call/return.
- Adds a parametrised return-address stack (RAS), pipeline stall and a reset vector.
- Sits between decode/ALU (branch, zero, imm, target) and instruction fetch, which is driven by the `pc` output.

---
 rtl/tinyrisc_pkg.sv | 16 +
 rtl/ras_stack.sv | 52 +++++
 rtl/pc_seq_unit.sv | 110 +++++++++++
 tb/tb_pc_seq_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tinyrisc_pkg.sv
// tinyRISC shared types and defaults.
// PC source encoding plus core-wide PC constants.
package tinyrisc_pkg;

  localparam int PC_W_DEF = 16;
  localparam logic [PC_W_DEF-1:0] RESET_VECTOR_DEF = '0;

  typedef enum logic [2:0] {
    PCSEL_SEQ,
    PCSEL_BR,
    PCSEL_JMP,
    PCSEL_CALL,
    PCSEL_RET
  } pcsel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
// A push onto a full stack overwrites the oldest entry.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] tp;
  logic [AW-1:0] tp_up;

  assign tp_up = tp + AW'(1);
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign top   = mem[tp];

  // Top pointer and occupancy; the slot above top is always the oldest when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp    <= '0;
      count <= '0;
    end else if (en) begin
      if (push) begin
        tp <= tp_up;
        if (!full) count <= count + CW'(1);
      end else if (pop && !empty) begin
        tp    <= tp - AW'(1);
        count <= count - CW'(1);
      end
    end
  end

  // Entry storage needs no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (en && push) mem[tp_up] <= push_data;
  end

endmodule

// File: rtl/pc_seq_unit.sv
// tinyRISC program-counter unit.
// Priority next-PC mux, PC register, RAS and sticky RAS error flags.
module pc_seq_unit
  import tinyrisc_pkg::*;
#(
  parameter int              PC_W         = PC_W_DEF,
  parameter int              IMM_W        = 16,
  parameter int              PC_INC       = 1,
  parameter int              RAS_DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         branch,
  input  logic                         zero,
  input  logic [IMM_W-1:0]             imm,
  input  logic                         jump,
  input  logic                         call,
  input  logic                         ret,
  input  logic [PC_W-1:0]              target_address,
  input  logic                         clr_err,
  output logic [PC_W-1:0]              pc,
  output logic [PC_W-1:0]              next_pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_br;
  logic [PC_W-1:0] ras_top;
  logic            ras_full;
  logic            ras_empty;
  logic            push;
  logic            pop;
  logic            ovf_ev;
  logic            unf_ev;
  pcsel_e          sel;

  assign pc_seq = pc + PC_W'(PC_INC);
  assign pc_br  = pc + PC_W'($signed(imm));

  // ret masks call, so push and pop are mutually exclusive.
  assign push   = call && !ret;
  assign pop    = ret && !ras_empty;
  assign ovf_ev = push && ras_full && !stall;
  assign unf_ev = ret && ras_empty && !stall;

  // Next-PC source, highest priority first.
  always_comb begin
    sel = PCSEL_SEQ;
    priority case (1'b1)
      ret && !ras_empty: sel = PCSEL_RET;
      ret:               sel = PCSEL_SEQ;
      call:              sel = PCSEL_CALL;
      jump:              sel = PCSEL_JMP;
      branch && zero:    sel = PCSEL_BR;
      default:           sel = PCSEL_SEQ;
    endcase
  end

  // Source to address mux.
  always_comb begin
    next_pc = pc_seq;
    unique case (sel)
      PCSEL_RET:  next_pc = ras_top;
      PCSEL_CALL: next_pc = target_address;
      PCSEL_JMP:  next_pc = target_address;
      PCSEL_BR:   next_pc = pc_br;
      default:    next_pc = pc_seq;
    endcase
  end

  // PC register, frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pc <= RESET_VECTOR;
    else if (!stall) pc <= next_pc;
  end

  // Sticky error flags; clear works even in a stall, a new error wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (ovf_ev)       ras_overflow  <= 1'b1;
      else if (clr_err) ras_overflow  <= 1'b0;
      if (unf_ev)       ras_underflow <= 1'b1;
      else if (clr_err) ras_underflow <= 1'b0;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (!stall),
    .push      (push),
    .pop       (pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit.
// Vector table plus directed stall and async-reset sequences.
module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, zero, jump, call, ret, clr_err;
  logic [15:0] imm, target_address;
  logic [15:0] pc, next_pc, pc2, next_pc2;
  logic [2:0]  ras_count, ras_count2;
  logic        ras_overflow, ras_underflow;
  logic        ovf2, unf2;

  int tests = 0;
  int fails = 0;

  localparam int S = 64, B = 32, Z = 16, J = 8, C = 4, R = 2, E = 1;

  typedef struct {
    int          ctl;
    logic [15:0] tgt;
    logic [15:0] imm;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t v[$];

  always #5 clk = ~clk;

  pc_seq_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch),
    .zero(zero), .imm(imm), .jump(jump), .call(call), .ret(ret),
    .target_address(target_address), .clr_err(clr_err),
    .pc(pc), .next_pc(next_pc), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  pc_seq_unit #(.RESET_VECTOR(16'h0100)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch),
    .zero(zero), .imm(imm), .jump(jump), .call(call), .ret(ret),
    .target_address(target_address), .clr_err(clr_err),
    .pc(pc2), .next_pc(next_pc2), .ras_count(ras_count2),
    .ras_overflow(ovf2), .ras_underflow(unf2)
  );

  function automatic vec_t mk(int ctl, logic [15:0] tgt,
                              logic [15:0] im, logic [15:0] e_pc,
                              logic [2:0] e_cnt, logic e_ovf,
                              logic e_unf);
    vec_t t;
    t.ctl = ctl; t.tgt = tgt; t.imm = im; t.e_pc = e_pc;
    t.e_cnt = e_cnt; t.e_ovf = e_ovf; t.e_unf = e_unf;
    return t;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int ctl, logic [15:0] tgt, logic [15:0] im);
    stall   = (ctl & S) != 0;
    branch  = (ctl & B) != 0;
    zero    = (ctl & Z) != 0;
    jump    = (ctl & J) != 0;
    call    = (ctl & C) != 0;
    ret     = (ctl & R) != 0;
    clr_err = (ctl & E) != 0;
    target_address = tgt;
    imm = im;
  endtask

  initial begin
    v.push_back(mk(0,         16'h0000, 16'h0000, 16'h0001, 0, 0, 0));
    v.push_back(mk(0,         16'h0000, 16'h0000, 16'h0002, 0, 0, 0));
    v.push_back(mk(0,         16'h0000, 16'h0000, 16'h0003, 0, 0, 0));
    v.push_back(mk(J,         16'h000A, 16'h0000, 16'h000A, 0, 0, 0));
    v.push_back(mk(B+Z,       16'h0000, 16'hFFFC, 16'h0006, 0, 0, 0));
    v.push_back(mk(J,         16'h000A, 16'h0000, 16'h000A, 0, 0, 0));
    v.push_back(mk(B,         16'h0000, 16'hFFFC, 16'h000B, 0, 0, 0));
    v.push_back(mk(J,         16'h0005, 16'h0000, 16'h0005, 0, 0, 0));
    v.push_back(mk(C,         16'h0040, 16'h0000, 16'h0040, 1, 0, 0));
    v.push_back(mk(C,         16'h0080, 16'h0000, 16'h0080, 2, 0, 0));
    v.push_back(mk(R,         16'h0000, 16'h0000, 16'h0041, 1, 0, 0));
    v.push_back(mk(R,         16'h0000, 16'h0000, 16'h0006, 0, 0, 0));
    v.push_back(mk(J,         16'h0001, 16'h0000, 16'h0001, 0, 0, 0));
    v.push_back(mk(C,         16'h0002, 16'h0000, 16'h0002, 1, 0, 0));
    v.push_back(mk(C,         16'h0003, 16'h0000, 16'h0003, 2, 0, 0));
    v.push_back(mk(C,         16'h0004, 16'h0000, 16'h0004, 3, 0, 0));
    v.push_back(mk(C,         16'h0005, 16'h0000, 16'h0005, 4, 0, 0));
    v.push_back(mk(C,         16'h0020, 16'h0000, 16'h0020, 4, 1, 0));
    v.push_back(mk(R,         16'h0000, 16'h0000, 16'h0006, 3, 1, 0));
    v.push_back(mk(R,         16'h0000, 16'h0000, 16'h0005, 2, 1, 0));
    v.push_back(mk(R,         16'h0000, 16'h0000, 16'h0004, 1, 1, 0));
    v.push_back(mk(R,         16'h0000, 16'h0000, 16'h0003, 0, 1, 0));
    v.push_back(mk(R,         16'h0000, 16'h0000, 16'h0004, 0, 1, 1));
    v.push_back(mk(E,         16'h0000, 16'h0000, 16'h0005, 0, 0, 0));
    v.push_back(mk(R+E,       16'h0000, 16'h0000, 16'h0006, 0, 0, 1));
    v.push_back(mk(S+E,       16'h0000, 16'h0000, 16'h0006, 0, 0, 0));
    v.push_back(mk(S+C,       16'h0050, 16'h0000, 16'h0006, 0, 0, 0));
    v.push_back(mk(J,         16'hFFFF, 16'h0000, 16'hFFFF, 0, 0, 0));
    v.push_back(mk(0,         16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    v.push_back(mk(C+J+B+Z,   16'h0300, 16'h0004, 16'h0300, 1, 0, 0));
    v.push_back(mk(R+C,       16'h0400, 16'h0000, 16'h0001, 0, 0, 0));
    v.push_back(mk(J+B+Z,     16'h0010, 16'h0004, 16'h0010, 0, 0, 0));
    v.push_back(mk(S+R,       16'h0000, 16'h0000, 16'h0010, 0, 0, 0));

    rst_n = 1'b0;
    drive(0, 16'h0000, 16'h0000);
    #12;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_cnt", 16'(ras_count), 16'h0000);
    chk("rst_ovf", 16'(ras_overflow), 16'h0000);
    chk("rst_unf", 16'(ras_underflow), 16'h0000);
    chk("rst_pc_vec", pc2, 16'h0100);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_pc_vec", pc2, 16'h0100);

    foreach (v[i]) begin
      drive(v[i].ctl, v[i].tgt, v[i].imm);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), pc, v[i].e_pc);
      chk($sformatf("v%0d_cnt", i), 16'(ras_count), 16'(v[i].e_cnt));
      chk($sformatf("v%0d_ovf", i), 16'(ras_overflow), 16'(v[i].e_ovf));
      chk($sformatf("v%0d_unf", i), 16'(ras_underflow), 16'(v[i].e_unf));
    end

    drive(S+J, 16'h0200, 16'h0000);
    #1;
    chk("stall_next", next_pc, 16'h0200);
    @(posedge clk);
    #1;
    chk("stall_pc", pc, 16'h0010);
    chk("stall_next2", next_pc, 16'h0200);
    drive(J, 16'h0200, 16'h0000);
    @(posedge clk);
    #1;
    chk("unstall_pc", pc, 16'h0200);

    drive(C, 16'h0500, 16'h0000);
    @(posedge clk);
    #1;
    chk("call_pc", pc, 16'h0500);
    chk("call_cnt", 16'(ras_count), 16'h0001);
    drive(C, 16'h0600, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_cnt", 16'(ras_count), 16'h0000);
    chk("arst_pc_vec", pc2, 16'h0100);
    drive(0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_pc", pc, 16'h0001);
    chk("post_rst_cnt", 16'(ras_count), 16'h0000);
    chk("post_rst_pc_vec", pc2, 16'h0101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
